da_wave_ctrl: RTL and testbench



---
 rtl/da_wave_ctrl_if.sv | 31 +++
 rtl/da_wave_ctrl.sv | 161 ++++++++++++++++
 tb/tb_da_wave_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/da_wave_ctrl_if.sv
// Host/ROM/DAC-side signal bundle for da_wave_ctrl.
// slave = controller view, master = host + ROM + DAC pin view.
interface da_wave_ctrl_if #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned SEL_W   = 2
);
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [2:0]                cfg_addr;
    logic [PHASE_W-1:0]        cfg_wdata;
    logic                      start;
    logic                      stop;
    logic [SEL_W+ADDR_W-1:0]   rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic                      da_clk;
    logic [DATA_W-1:0]         da_data;
    logic                      busy;
    logic                      done;

    modport slave (
        input  cfg_valid, cfg_addr, cfg_wdata, start, stop, rom_data,
        output cfg_ready, rom_addr, da_clk, da_data, busy, done
    );

    modport master (
        output cfg_valid, cfg_addr, cfg_wdata, start, stop, rom_data,
        input  cfg_ready, rom_addr, da_clk, da_data, busy, done
    );
endinterface

// File: rtl/da_wave_ctrl.sv
// DA waveform controller: config regs, phase-accumulator ROM addressing, burst control, DAC pipeline.
// Build macro DA_WAVE_AMP_EN enables the amplitude scaler on register 4.
module da_wave_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned BURST_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    da_wave_ctrl_if.slave bus
);
    localparam int unsigned ROM_AW = SEL_W + ADDR_W;
    localparam logic [DATA_W-1:0]  MID     = DATA_W'(1 << (DATA_W - 1));
    localparam logic [PHASE_W-1:0] INC_RST = PHASE_W'(10 << (PHASE_W - ADDR_W));

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH} state_e;

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_acc_q, phase_acc_d;
    logic [BURST_W-1:0]   cyc_cnt_q, cyc_cnt_d, cyc_inc;
    logic [ROM_AW-1:0]    rom_addr_q, rom_addr_d;
    logic                 flush_cnt_q, flush_cnt_d;
    logic                 done_q, done_d;
    logic                 busy_q, cfg_ready_q;
    logic                 v1_q, v2_q;
    logic [DATA_W-1:0]    da_data_q, sample;
    logic [PHASE_W:0]     acc_sum;
    logic                 carry;
    logic                 cfg_fire;

    logic [PHASE_W-1:0]   phase_inc_q, phase_off_q;
    logic [SEL_W-1:0]     wave_sel_q;
    logic [BURST_W-1:0]   burst_q;

    assign cfg_fire = bus.cfg_valid && cfg_ready_q;

`ifdef DA_WAVE_AMP_EN
    localparam int unsigned AMP_W     = 9;
    localparam int unsigned AMP_UNITY = 256;
    localparam int unsigned AMP_SH    = 8;
    localparam int unsigned PROD_W    = DATA_W + AMP_W + 1;

    logic [AMP_W-1:0]          amp_q;
    logic signed [DATA_W:0]    diff;
    logic signed [PROD_W-1:0]  prod;

    // Scale the sample around midscale; arithmetic shift keeps negative swings symmetric.
    always_comb begin
        diff   = $signed({1'b0, bus.rom_data}) - $signed({1'b0, MID});
        prod   = PROD_W'(diff) * PROD_W'($signed({1'b0, amp_q}));
        sample = DATA_W'((prod >>> AMP_SH) + PROD_W'($signed({1'b0, MID})));
    end
`else
    assign sample = bus.rom_data;
`endif

    // Configuration register file; only writable while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_inc_q <= INC_RST;
            wave_sel_q  <= '0;
            burst_q     <= '0;
            phase_off_q <= '0;
`ifdef DA_WAVE_AMP_EN
            amp_q       <= AMP_W'(AMP_UNITY);
`endif
        end else if (cfg_fire) begin
            case (bus.cfg_addr)
                3'd0: phase_inc_q <= bus.cfg_wdata;
                3'd1: wave_sel_q  <= bus.cfg_wdata[SEL_W-1:0];
                3'd2: burst_q     <= bus.cfg_wdata[BURST_W-1:0];
                3'd3: phase_off_q <= bus.cfg_wdata;
`ifdef DA_WAVE_AMP_EN
                3'd4: amp_q <= (bus.cfg_wdata > PHASE_W'(AMP_UNITY)) ? AMP_W'(AMP_UNITY)
                                                                     : bus.cfg_wdata[AMP_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Next-state and address generation.
    always_comb begin
        state_d     = state_q;
        phase_acc_d = phase_acc_q;
        cyc_cnt_d   = cyc_cnt_q;
        rom_addr_d  = rom_addr_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        acc_sum     = {1'b0, phase_acc_q} + {1'b0, phase_inc_q};
        carry       = acc_sum[PHASE_W];
        cyc_inc     = cyc_cnt_q + BURST_W'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) state_d = S_LOAD;
            end
            S_LOAD: begin
                phase_acc_d = phase_off_q;
                cyc_cnt_d   = '0;
                rom_addr_d  = {wave_sel_q, phase_off_q[PHASE_W-1 -: ADDR_W]};
                state_d     = S_RUN;
            end
            S_RUN: begin
                phase_acc_d = acc_sum[PHASE_W-1:0];
                rom_addr_d  = {wave_sel_q, acc_sum[PHASE_W-1 -: ADDR_W]};
                if (carry) cyc_cnt_d = cyc_inc;
                if (bus.stop || ((burst_q != '0) && carry && (cyc_inc == burst_q))) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 1'b0;
                end
            end
            S_FLUSH: begin
                flush_cnt_d = 1'b1;
                if (flush_cnt_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, address and output pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_acc_q <= '0;
            cyc_cnt_q   <= '0;
            rom_addr_q  <= '0;
            flush_cnt_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            da_data_q   <= MID;
        end else begin
            state_q     <= state_d;
            phase_acc_q <= phase_acc_d;
            cyc_cnt_q   <= cyc_cnt_d;
            rom_addr_q  <= rom_addr_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
            busy_q      <= (state_d != S_IDLE);
            cfg_ready_q <= (state_d == S_IDLE);
            v1_q        <= (state_q == S_LOAD) || (state_q == S_RUN);
            v2_q        <= v1_q;
            da_data_q   <= v2_q ? sample : MID;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.da_clk    = ~clk;
    assign bus.da_data   = da_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_da_wave_ctrl.sv
// Self-checking bench for da_wave_ctrl: per-cycle expectations derived from phase arithmetic
// over a randomly filled ROM image, compared against captured DUT outputs.
module tb_da_wave_ctrl;
    localparam int unsigned MID = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    int unsigned sh_inc, sh_sel, sh_burst, sh_off, sh_amp;
    logic [9:0]  rom_mem  [4096];
    logic [11:0] exp_addr [512];
    logic [11:0] obs_addr [512];
    logic [9:0]  exp_da   [512];
    logic [9:0]  obs_da   [512];
    logic        exp_busy [512];
    logic        exp_done [512];
    logic        obs_busy [512];
    logic        obs_done [512];
    logic        obs_rdy  [512];
    int          n_obs;
    int          k_end;

    always #5 clk = ~clk;

    da_wave_ctrl_if bus ();
    da_wave_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // ROM image with one clock of read latency
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] scale(input logic [9:0] s);
`ifdef DA_WAVE_AMP_EN
        int d;
        d = int'(s) - 512;
        return 10'(512 + ((d * int'(sh_amp)) >>> 8));
`else
        return s;
`endif
    endfunction

    function automatic logic [11:0] addr_at(input int k);
        longint p;
        p = (longint'(sh_off) + longint'(k) * longint'(sh_inc)) & 64'h0000_0000_00FF_FFFF;
        return 12'((longint'(sh_sel) << 10) | (p >> 14));
    endfunction

    task automatic shadow_reset();
        sh_inc = 10 << 14; sh_sel = 0; sh_burst = 0; sh_off = 0; sh_amp = 256;
    endtask

    task automatic cfg_write(input int unsigned a, input int unsigned d);
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_addr = 3'(a); bus.cfg_wdata = 24'(d);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        case (a)
            0: sh_inc   = d & 32'h00FF_FFFF;
            1: sh_sel   = d & 32'h3;
            2: sh_burst = d & 32'hFFFF;
            3: sh_off   = d & 32'h00FF_FFFF;
            4: sh_amp   = (d > 256) ? 256 : d;
            default: ;
        endcase
    endtask

    // Expected per-cycle outputs; j=0 is the edge that samples start.
    task automatic build_expect(input int stop_s);
        longint tot;
        k_end = 0;
        for (int n = 1; n < 480; n++) begin
            tot   = longint'(sh_off) + longint'(n) * longint'(sh_inc);
            k_end = n;
            if (sh_burst != 0 && (tot >> 24) == longint'(sh_burst)) break;
            if (n == stop_s - 1) break;
        end
        n_obs = k_end + 6;
        for (int j = 0; j < n_obs; j++) begin
            exp_busy[j] = (j <= k_end + 2);
            exp_done[j] = (j == k_end + 3);
            exp_addr[j] = addr_at((j - 1 < k_end) ? j - 1 : k_end);
            exp_da[j]   = (j >= 3 && j - 3 <= k_end) ? scale(rom_mem[addr_at(j - 3)]) : 10'(MID);
        end
    endtask

    task automatic capture(input int stop_s, input int wr_j);
        @(negedge clk);
        bus.start = 1'b1;
        for (int j = 0; j < n_obs; j++) begin
            @(negedge clk);
            obs_addr[j] = bus.rom_addr; obs_da[j] = bus.da_data;
            obs_busy[j] = bus.busy;     obs_done[j] = bus.done; obs_rdy[j] = bus.cfg_ready;
            bus.start = 1'b0;
            bus.stop  = (j + 1 == stop_s);
            bus.cfg_valid = (j == wr_j);
            bus.cfg_addr  = 3'd0;
            bus.cfg_wdata = 24'h03_FFFF;
        end
        bus.stop = 1'b0; bus.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.start = 1'b0; bus.stop = 1'b0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 10'($urandom);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        shadow_reset();
        repeat (20) @(negedge clk);
        n_checks++;
        if (bus.da_data !== 10'(MID)) begin n_fail++; $display("FAIL reset_da: got %0d want %0d", bus.da_data, MID); end
        n_checks++;
        if (bus.rom_addr !== 12'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.rom_addr); end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", bus.busy, bus.done); end
        n_checks++;
        if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cfg_ready); end
        n_checks++;
        if (bus.da_clk !== ~clk) begin n_fail++; $display("FAIL da_clk: got %b want %b", bus.da_clk, ~clk); end
    endtask

    task automatic test_defaults();
        build_expect(40);
        capture(40, -1);
        for (int j = 0; j < n_obs; j++) begin
            n_checks++;
            if (obs_busy[j] !== exp_busy[j] || obs_done[j] !== exp_done[j] || obs_rdy[j] !== ~exp_busy[j] ||
                (j >= 1 && obs_addr[j] !== exp_addr[j]) || obs_da[j] !== exp_da[j]) begin
                n_fail++;
                $display("FAIL defaults cyc %0d: got addr=%0d da=%0d b/d/r=%b%b%b want addr=%0d da=%0d b/d=%b%b",
                         j, obs_addr[j], obs_da[j], obs_busy[j], obs_done[j], obs_rdy[j], exp_addr[j], exp_da[j], exp_busy[j], exp_done[j]);
            end
        end
    endtask

    task automatic test_burst();
        int dones, busys;
        cfg_write(2, 2);
        cfg_write(0, 1 << 20);
        build_expect(0);
        capture(0, -1);
        dones = 0; busys = 0;
        for (int j = 0; j < n_obs; j++) begin
            dones += int'(obs_done[j]);
            busys += int'(obs_busy[j]);
            n_checks++;
            if (obs_busy[j] !== exp_busy[j] || obs_done[j] !== exp_done[j] || obs_rdy[j] !== ~exp_busy[j] ||
                (j >= 1 && obs_addr[j] !== exp_addr[j]) || obs_da[j] !== exp_da[j]) begin
                n_fail++;
                $display("FAIL burst cyc %0d: got addr=%0d da=%0d b/d/r=%b%b%b want addr=%0d da=%0d b/d=%b%b",
                         j, obs_addr[j], obs_da[j], obs_busy[j], obs_done[j], obs_rdy[j], exp_addr[j], exp_da[j], exp_busy[j], exp_done[j]);
            end
        end
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL burst_done_count: got %0d want 1", dones); end
        n_checks++;
        if (busys !== 35) begin n_fail++; $display("FAIL burst_busy_cycles: got %0d want 35", busys); end
        n_checks++;
        if (obs_da[n_obs-1] !== 10'(MID)) begin n_fail++; $display("FAIL burst_idle_da: got %0d want %0d", obs_da[n_obs-1], MID); end
        cfg_write(2, 0);
    endtask

    task automatic test_stop();
        int s;
        cfg_write(0, $urandom_range(1 << 16, 1 << 22));
        cfg_write(1, $urandom_range(0, 3));
        cfg_write(3, $urandom & 32'h00FF_FFFF);
        s = $urandom_range(5, 60);
        build_expect(s);
        capture(s, -1);
        for (int j = 0; j < n_obs; j++) begin
            n_checks++;
            if (obs_busy[j] !== exp_busy[j] || obs_done[j] !== exp_done[j] || obs_rdy[j] !== ~exp_busy[j] ||
                (j >= 1 && obs_addr[j] !== exp_addr[j]) || obs_da[j] !== exp_da[j]) begin
                n_fail++;
                $display("FAIL stop cyc %0d: got addr=%0d da=%0d b/d/r=%b%b%b want addr=%0d da=%0d b/d=%b%b",
                         j, obs_addr[j], obs_da[j], obs_busy[j], obs_done[j], obs_rdy[j], exp_addr[j], exp_da[j], exp_busy[j], exp_done[j]);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL start_stop_idle cyc %0d: got b/d/r=%b%b%b want 001", i, bus.busy, bus.done, bus.cfg_ready);
            end
        end
        bus.start = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic test_cfg_busy();
        build_expect(30);
        capture(30, 10);
        n_checks++;
        if (obs_rdy[10] !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", obs_rdy[10]); end
        cfg_write(1, 3);
        build_expect(20);
        capture(20, -1);
        for (int j = 0; j < n_obs; j++) begin
            n_checks++;
            if (obs_busy[j] !== exp_busy[j] || obs_done[j] !== exp_done[j] || obs_rdy[j] !== ~exp_busy[j] ||
                (j >= 1 && obs_addr[j] !== exp_addr[j]) || obs_da[j] !== exp_da[j]) begin
                n_fail++;
                $display("FAIL cfg_held cyc %0d: got addr=%0d da=%0d b/d/r=%b%b%b want addr=%0d da=%0d b/d=%b%b",
                         j, obs_addr[j], obs_da[j], obs_busy[j], obs_done[j], obs_rdy[j], exp_addr[j], exp_da[j], exp_busy[j], exp_done[j]);
            end
        end
        n_checks++;
        if (obs_addr[5][11:10] !== 2'd3) begin n_fail++; $display("FAIL wave_sel: got %0d want 3", obs_addr[5][11:10]); end
    endtask

    task automatic test_amplitude();
        logic [9:0] hi_exp, lo_exp;
`ifdef DA_WAVE_AMP_EN
        hi_exp = 10'd767; lo_exp = 10'd256;
`else
        hi_exp = 10'd1023; lo_exp = 10'd0;
`endif
        rom_mem[0] = 10'd1023; rom_mem[1] = 10'd0;
        cfg_write(0, 1 << 14); cfg_write(1, 0); cfg_write(3, 0); cfg_write(4, 128);
        build_expect(3);
        capture(3, -1);
        n_checks++;
        if (obs_da[3] !== hi_exp) begin n_fail++; $display("FAIL amp_hi: got %0d want %0d", obs_da[3], hi_exp); end
        n_checks++;
        if (obs_da[4] !== lo_exp) begin n_fail++; $display("FAIL amp_lo: got %0d want %0d", obs_da[4], lo_exp); end
        cfg_write(4, 300);
        build_expect(3);
        capture(3, -1);
        n_checks++;
        if (obs_da[3] !== 10'd1023 || obs_da[4] !== 10'd0) begin
            n_fail++; $display("FAIL amp_clamp: got %0d/%0d want 1023/0", obs_da[3], obs_da[4]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            cfg_write(0, $urandom_range(1 << 18, 1 << 23));
            cfg_write(1, $urandom_range(0, 3));
            cfg_write(3, $urandom & 32'h00FF_FFFF);
            cfg_write(2, $urandom_range(1, 3));
            build_expect(0);
            capture(0, -1);
            for (int j = 0; j < n_obs; j++) begin
                n_checks++;
                if (obs_busy[j] !== exp_busy[j] || obs_done[j] !== exp_done[j] || obs_rdy[j] !== ~exp_busy[j] ||
                    (j >= 1 && obs_addr[j] !== exp_addr[j]) || obs_da[j] !== exp_da[j]) begin
                    n_fail++;
                    $display("FAIL random%0d cyc %0d: got addr=%0d da=%0d b/d/r=%b%b%b want addr=%0d da=%0d b/d=%b%b",
                             i, j, obs_addr[j], obs_da[j], obs_busy[j], obs_done[j], obs_rdy[j], exp_addr[j], exp_da[j], exp_busy[j], exp_done[j]);
                end
            end
        end
        cfg_write(2, 0);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL run_before_reset: got busy=%b want 1", bus.busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        shadow_reset();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cfg_ready !== 1'b1 ||
            bus.da_data !== 10'(MID) || bus.rom_addr !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got b/d/r=%b%b%b da=%0d addr=%0d want 001 da=512 addr=0",
                     bus.busy, bus.done, bus.cfg_ready, bus.da_data, bus.rom_addr);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_reset_after cyc %0d: got b/d=%b%b want 00", i, bus.busy, bus.done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_burst();
        test_stop();
        test_start_stop_idle();
        test_cfg_busy();
        test_amplitude();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
